seq_mux_scan: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer. It is the next-generation replacement for the fixed 4:1 single-bit mux. Two modes are supported: manual select, and an automatic round-robin scan with a programmable dwell time and a per-channel enable mask. It sits between multi-source data inputs and a single downstream consumer that needs a registered sample, its channel index and a channel-change strobe.

---
 rtl/seq_mux_scan.sv | 185 ++++++++++++++++++
 tb/tb_seq_mux_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mux_scan.sv
// ---------------------------------------------------------------------------
// seq_mux_scan
//
// Registered N-channel, W-bit multiplexer with two modes:
//   manual - the channel named by sel drives y (if that channel is enabled)
//   scan   - enabled channels are visited round-robin, each held for
//            max(dwell,1) cycles
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   din      in   CHANNELS*WIDTH, channel i at din[i*WIDTH +: WIDTH]
//   sel      in   SELW, manual channel select
//   mode     in   0 = manual, 1 = scan
//   en_mask  in   CHANNELS, bit i enables channel i
//   dwell    in   DWELL_W, cycles per channel in scan mode (0 acts as 1)
//   y        out  WIDTH, registered selected data
//   y_ch     out  SELW, index of the channel driving y
//   y_valid  out  y/y_ch hold a sample from an enabled channel
//   strobe   out  one-cycle pulse in the first cycle of a newly selected channel
// ---------------------------------------------------------------------------
module seq_mux_scan #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 4,
    parameter  int DWELL_W  = 8,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       en_mask,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [WIDTH-1:0]          y,
    output logic [SELW-1:0]           y_ch,
    output logic                      y_valid,
    output logic                      strobe
);

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;

    logic [WIDTH-1:0]     r_y;
    logic [SELW-1:0]      r_ych;
    logic                 r_valid;
    logic                 r_strobe;
    logic [DWELL_W-1:0]   r_cnt;

    logic [WIDTH-1:0]     w_yNext;
    logic [SELW-1:0]      w_ychNext;
    logic                 w_validNext;
    logic                 w_strobeNext;
    logic [DWELL_W-1:0]   w_cntNext;

    logic [DWELL_W-1:0]   w_dwellLast;
    logic                 w_selOk;
    logic [SELW-1:0]      w_chFirst;
    logic [SELW-1:0]      w_chAdvance;
    logic [SELW-1:0]      w_chAfter;

    logic [WIDTH-1:0]     w_chan [CHANNELS];

    // Explicit wrap so a non-power-of-two channel count never produces an
    // out-of-range index.
    function automatic logic [SELW-1:0] wrapInc(input logic [SELW-1:0] idx);
        if (idx == SELW'(CHANNELS - 1)) begin
            return '0;
        end
        return idx + SELW'(1);
    endfunction

    // Lowest enabled index at or after start, wrapping once round the ring.
    // Returns start when nothing is enabled (never used in that case).
    function automatic logic [SELW-1:0] firstEnabled(
        input logic [SELW-1:0]     start,
        input logic [CHANNELS-1:0] mask
    );
        logic [SELW-1:0] idx;
        logic [SELW-1:0] res;
        logic            found;
        idx   = start;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && mask[idx]) begin
                found = 1'b1;
                res   = idx;
            end
            idx = wrapInc(idx);
        end
        return res;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_chan[g] = din[g*WIDTH +: WIDTH];
    end

    // Next state and next register values. The mode decision is taken from
    // this cycle's inputs so the outputs follow them with one cycle of latency;
    // r_state remembers the previous mode so that entry into scan is visible.
    always_comb begin
        w_stateNext  = IDLE;
        w_yNext      = r_y;
        w_ychNext    = r_ych;
        w_validNext  = 1'b0;
        w_strobeNext = 1'b0;
        w_cntNext    = '0;
        w_chAfter    = r_ych;

        if (en_mask == '0) begin
            w_stateNext = IDLE;
        end else if (!mode) begin
            w_stateNext = MANUAL;
        end else begin
            w_stateNext = SCAN;
        end

        w_dwellLast = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        w_selOk     = (32'(sel) < CHANNELS) && en_mask[sel];
        w_chFirst   = firstEnabled(r_ych, en_mask);
        w_chAdvance = firstEnabled(wrapInc(r_ych), en_mask);

        case (w_stateNext)
            MANUAL: begin
                if (w_selOk) begin
                    w_yNext      = w_chan[sel];
                    w_ychNext    = sel;
                    w_validNext  = 1'b1;
                    w_strobeNext = (sel != r_ych) || !r_valid;
                end
            end
            SCAN: begin
                if (r_state != SCAN) begin
                    w_chAfter    = w_chFirst;
                    w_strobeNext = 1'b1;
                end else if (!en_mask[r_ych] || (r_cnt >= w_dwellLast)) begin
                    // Dwell expired, the dwell was shortened below the count,
                    // or the current channel was masked off.
                    w_chAfter    = w_chAdvance;
                    w_strobeNext = 1'b1;
                end else begin
                    w_chAfter = r_ych;
                    w_cntNext = r_cnt + DWELL_W'(1);
                end
                w_yNext     = w_chan[w_chAfter];
                w_ychNext   = w_chAfter;
                w_validNext = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_y      <= '0;
            r_ych    <= '0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_y      <= w_yNext;
            r_ych    <= w_ychNext;
            r_valid  <= w_validNext;
            r_strobe <= w_strobeNext;
            r_cnt    <= w_cntNext;
        end
    end

    assign y       = r_y;
    assign y_ch    = r_ych;
    assign y_valid = r_valid;
    assign strobe  = r_strobe;

endmodule

// File: tb/tb_seq_mux_scan.sv
// ---------------------------------------------------------------------------
// tb_seq_mux_scan
//
// Directed bench for seq_mux_scan (WIDTH=8, CHANNELS=4, DWELL_W=8): reset,
// manual select, round-robin scan, mask changes, dwell=0, disabled manual
// select and reset in the middle of a scan.
// ---------------------------------------------------------------------------
module tb_seq_mux_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] din = '0;
    logic [1:0]  sel = '0;
    logic        mode = 1'b0;
    logic [3:0]  en_mask = '0;
    logic [7:0]  dwell = '0;
    logic [7:0]  y;
    logic [1:0]  y_ch;
    logic        y_valid;
    logic        strobe;

    int testCount = 0;
    int failCount = 0;

    localparam logic [31:0] DIN_SCAN = {8'h44, 8'h33, 8'h22, 8'h11};
    localparam logic [31:0] DIN_BITS = {8'h01, 8'h00, 8'h01, 8'h00};

    logic [7:0] manualY   [4]  = '{8'h00, 8'h01, 8'h00, 8'h01};
    logic [7:0] scanY     [13] = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22,
                                   8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44,
                                   8'h11};
    logic       scanStb   [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] skipCh    [10] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3,
                                   2'd1, 2'd1, 2'd1, 2'd3};
    logic       skipStb   [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                   1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] fastCh    [4]  = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] fastY     [4]  = '{8'h22, 8'h33, 8'h44, 8'h11};

    seq_mux_scan #(
        .WIDTH    (8),
        .CHANNELS (4),
        .DWELL_W  (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .sel     (sel),
        .mode    (mode),
        .en_mask (en_mask),
        .dwell   (dwell),
        .y       (y),
        .y_ch    (y_ch),
        .y_valid (y_valid),
        .strobe  (strobe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic [31:0] d,
        input logic [1:0]  s,
        input logic        m,
        input logic [3:0]  msk,
        input logic [7:0]  dw
    );
        din     = d;
        sel     = s;
        mode    = m;
        en_mask = msk;
        dwell   = dw;
    endtask

    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int strobeSum;

        // Reset held with active inputs.
        applyStimulus(DIN_SCAN, 2'd1, 1'b0, 4'hF, 8'd3);
        #2 rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset_y",      32'(y),       32'h00);
        checkOutput("reset_ych",    32'(y_ch),    32'd0);
        checkOutput("reset_valid",  32'(y_valid), 32'd0);
        checkOutput("reset_strobe", 32'(strobe),  32'd0);

        // Release: valid rises one cycle after the enabled select.
        rst_n = 1'b1;
        tick();
        checkOutput("release_valid",  32'(y_valid), 32'd1);
        checkOutput("release_y",      32'(y),       32'h22);
        checkOutput("release_ych",    32'(y_ch),    32'd1);
        checkOutput("release_strobe", 32'(strobe),  32'd1);

        // Manual 4:1 regression on pattern 1010.
        for (int s = 0; s < 4; s++) begin
            applyStimulus(DIN_BITS, 2'(s), 1'b0, 4'hF, 8'd3);
            tick();
            checkOutput($sformatf("manual_y_%0d", s),      32'(y),      32'(manualY[s]));
            checkOutput($sformatf("manual_ych_%0d", s),    32'(y_ch),   32'(s));
            checkOutput($sformatf("manual_strobe_%0d", s), 32'(strobe), 32'd1);
            strobeSum = 0;
            for (int c = 0; c < 9; c++) begin
                tick();
                strobeSum += int'(strobe);
            end
            checkOutput($sformatf("manual_hold_%0d", s), 32'(strobeSum), 32'd0);
        end

        // Manual select of a disabled channel holds y and drops valid.
        applyStimulus(DIN_BITS, 2'd2, 1'b0, 4'b1011, 8'd3);
        tick();
        checkOutput("dis_valid",  32'(y_valid), 32'd0);
        checkOutput("dis_y",      32'(y),       32'h01);
        checkOutput("dis_ych",    32'(y_ch),    32'd3);
        checkOutput("dis_strobe", 32'(strobe),  32'd0);
        applyStimulus(DIN_BITS, 2'd3, 1'b0, 4'b1011, 8'd3);
        tick();
        checkOutput("reen_valid",  32'(y_valid), 32'd1);
        checkOutput("reen_strobe", 32'(strobe),  32'd1);

        // Scan with dwell 3 across all four channels and wrap.
        applyStimulus(DIN_SCAN, 2'd0, 1'b0, 4'hF, 8'd3);
        tick();
        applyStimulus(DIN_SCAN, 2'd0, 1'b1, 4'hF, 8'd3);
        for (int k = 0; k < 13; k++) begin
            tick();
            checkOutput($sformatf("scan_y_%0d", k),      32'(y),      32'(scanY[k]));
            checkOutput($sformatf("scan_strobe_%0d", k), 32'(strobe), 32'(scanStb[k]));
        end

        // Mask 1010 skips disabled channels.
        applyStimulus(DIN_SCAN, 2'd0, 1'b1, 4'b1010, 8'd3);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput($sformatf("skip_ych_%0d", k),    32'(y_ch),   32'(skipCh[k]));
            checkOutput($sformatf("skip_strobe_%0d", k), 32'(strobe), 32'(skipStb[k]));
        end

        // Removing the current channel mid-dwell forces an advance.
        applyStimulus(DIN_SCAN, 2'd0, 1'b1, 4'b0010, 8'd3);
        tick();
        checkOutput("drop_ych",    32'(y_ch),   32'd1);
        checkOutput("drop_strobe", 32'(strobe), 32'd1);
        tick();
        checkOutput("single_hold1", 32'(strobe), 32'd0);
        tick();
        checkOutput("single_hold2", 32'(strobe), 32'd0);
        tick();
        checkOutput("single_wrap_strobe", 32'(strobe), 32'd1);
        checkOutput("single_wrap_ych",    32'(y_ch),   32'd1);

        // Empty mask: idle, y holds.
        applyStimulus(DIN_SCAN, 2'd0, 1'b1, 4'b0000, 8'd3);
        tick();
        checkOutput("idle_valid",  32'(y_valid), 32'd0);
        checkOutput("idle_y",      32'(y),       32'h22);
        checkOutput("idle_strobe", 32'(strobe),  32'd0);

        // dwell 0 advances every cycle.
        applyStimulus(DIN_SCAN, 2'd0, 1'b1, 4'hF, 8'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("fast_ych_%0d", k),    32'(y_ch),   32'(fastCh[k]));
            checkOutput($sformatf("fast_y_%0d", k),      32'(y),      32'(fastY[k]));
            checkOutput($sformatf("fast_strobe_%0d", k), 32'(strobe), 32'd1);
        end

        // Reset while on channel 2 at count 1.
        applyStimulus(DIN_SCAN, 2'd0, 1'b1, 4'hF, 8'd3);
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        checkOutput("midscan_ych",    32'(y_ch),   32'd2);
        checkOutput("midscan_strobe", 32'(strobe), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_y",      32'(y),       32'h00);
        checkOutput("async_ych",    32'(y_ch),    32'd0);
        checkOutput("async_valid",  32'(y_valid), 32'd0);
        checkOutput("async_strobe", 32'(strobe),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("restart_ych",    32'(y_ch),    32'd0);
        checkOutput("restart_y",      32'(y),       32'h11);
        checkOutput("restart_strobe", 32'(strobe),  32'd1);
        checkOutput("restart_valid",  32'(y_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
